// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives S/R of an external NOR SR latch with one clean pulse per
// request, then confirms the new level through synchronised Q feedback.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid, req_level request handshake; level 1 = set (S pulse), 0 = clear (R pulse)
//   req_ready            high only while IDLE
//   S, R                 registered latch drives, never high together
//   Q_fb                 latch Q, asynchronous to clk
//   busy                 high outside IDLE
//   done, err            one-cycle completion pulse; err marks a feedback timeout
//   level_q              last confirmed latch level
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic Q_fb,
  output logic busy,
  output logic done,
  output logic err,
  output logic level_q
);
  localparam int MAX_PG = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int MAX_C  = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
  localparam int CW     = $clog2(MAX_C + 1);
  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;
  state_t          r_state;
  logic            r_lvl;
  logic            r_q_meta;
  logic            r_q_sync;
  logic [CW-1:0]   r_cnt;
  logic            w_accept;
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = req_valid & req_ready;
  // One counter serves all three timed phases; each phase entry zeroes it.
  // The CHECK timeout fires on the TIMEOUT-th consecutive mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_lvl    <= 1'b0;
      r_q_meta <= 1'b0;
      r_q_sync <= 1'b0;
      r_cnt    <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      r_q_meta <= Q_fb;
      r_q_sync <= r_q_meta;
      done     <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_lvl <= req_level;
          if (req_level == r_q_sync) begin
            done    <= 1'b1;
            level_q <= req_level;
          end else begin
            r_state <= PULSE;
            r_cnt   <= '0;
            S       <= req_level;
            R       <= ~req_level;
          end
        end
        PULSE: if (r_cnt == CW'(PULSE_W - 1)) begin
          S       <= 1'b0;
          R       <= 1'b0;
          r_cnt   <= '0;
          r_state <= (GAP_W == 0) ? CHECK : GAP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        GAP: if (r_cnt == CW'(GAP_W - 1)) begin
          r_cnt   <= '0;
          r_state <= CHECK;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        CHECK: if (r_q_sync == r_lvl) begin
          done    <= 1'b1;
          level_q <= r_lvl;
          r_cnt   <= '0;
          r_state <= IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          done    <= 1'b1;
          err     <= 1'b1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: scoreboard bench for sr_latch_driver with a behavioural NOR latch
module tb_sr_latch_driver;
  localparam int P = 4;
  localparam int G = 2;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_level = 1'b0;
  logic stuck = 1'b0;
  logic q_l = 1'b0;
  logic Q_fb;
  logic req_ready, S, R, busy, done, err, level_q;
  typedef struct {int t; logic e; logic l;} exp_t;
  exp_t sb[$];
  exp_t ev;
  int cyc = 0;
  int next_free = 0;
  int p_start = 0;
  int p_end = -1;
  logic p_lvl = 1'b0;
  logic m_level = 1'b0;
  logic m_q;
  logic m_ok;
  int m_dt;
  int checks = 0;
  int failures = 0;
  sr_latch_driver #(.PULSE_W(P), .GAP_W(G), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .S(S), .R(R), .Q_fb(Q_fb), .busy(busy),
    .done(done), .err(err), .level_q(level_q)
  );
  always #5 clk = ~clk;
  assign Q_fb = stuck ? 1'b0 : q_l;
  always @(S or R) begin
    if (S && !R) q_l = 1'b1;
    else if (R && !S) q_l = 1'b0;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", n, cyc, a, e);
    end
  endtask
  // Reference model: decides acceptance from its own view of when the block is free,
  // and predicts pulse window, completion cycle, err and confirmed level.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      next_free = 0;
      p_end = -1;
      m_level = 1'b0;
    end else if (req_valid && cyc >= next_free) begin
      m_q = stuck ? 1'b0 : q_l;
      if (req_level == m_q) begin
        sb.push_back('{cyc + 1, 1'b0, req_level});
        m_level = req_level;
        next_free = cyc + 1;
      end else begin
        m_ok = !stuck;
        m_dt = m_ok ? P + G + 2 : P + G + T + 1;
        p_start = cyc + 1;
        p_end = cyc + P;
        p_lvl = req_level;
        if (m_ok) m_level = req_level;
        sb.push_back('{cyc + m_dt, !m_ok, m_level});
        next_free = cyc + m_dt;
      end
    end
    cyc++;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_and_r", S & R, 0);
      chk("S", S, p_lvl && cyc >= p_start && cyc <= p_end);
      chk("R", R, !p_lvl && cyc >= p_start && cyc <= p_end);
      chk("req_ready", req_ready, cyc >= next_free);
      chk("busy", busy, cyc < next_free);
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          ev = sb.pop_front();
          chk("done_cycle", cyc, ev.t);
          chk("err", err, ev.e);
          chk("level_q", level_q, ev.l);
        end
      end else begin
        chk("err_without_done", err, 0);
        if (sb.size() > 0 && sb[0].t <= cyc) begin
          chk("done_missing", done, 1);
          void'(sb.pop_front());
        end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic lv);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_level = lv;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end
  initial begin
    idle(3);
    chk("rst_S", S, 0);
    chk("rst_R", R, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_level_q", level_q, 0);
    rst_n = 1'b1;
    idle(3);
    send(1'b1); drain();
    send(1'b1); drain();
    send(1'b0); drain();
    stuck = 1'b1;
    idle(3);
    send(1'b1); drain();
    stuck = 1'b0;
    idle(4);
    req_valid = 1'b1;
    req_level = ~q_l;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) req_level = ~req_level;
    end
    req_valid = 1'b0;
    drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) != 0);
      req_level = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    drain();
    idle(2);
    send(~q_l);
    #2 rst_n = 1'b0;
    #1;
    chk("async_S", S, 0);
    chk("async_R", R, 0);
    chk("async_ready", req_ready, 1);
    chk("async_busy", busy, 0);
    chk("async_done", done | err, 0);
    chk("async_level_q", level_q, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    send(~q_l); drain();
    send(~q_l); drain();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous front-end that drives the S/R inputs of an external cross-coupled NOR SR latch and confirms the result through the latch's Q output.
- Accepts level requests (set/clear) over a valid/ready handshake and emits a single clean S or R pulse of fixed width, followed by a dead-time gap.
- Checks the synchronised Q feedback and reports completion or a timeout error.
- Guarantees S and R are never high together, so the latch never sees its forbidden input.

Parameters:
- PULSE_W, 4: cycles S or R is held high per request; legal range >=1.
- GAP_W, 2: dead-time cycles with S=R=0 after the pulse, before checking starts; 0 skips the GAP state.
- TIMEOUT, 16: maximum CHECK cycles to wait for feedback to match; legal range >=1.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- req_valid, input, 1: request present.
- req_level, input, 1: requested latch level; 1 = set (pulse S), 0 = clear (pulse R).
- req_ready, output, 1: block can accept a request; high only in IDLE.
- S, output, 1: set drive to the latch; registered.
- R, output, 1: reset drive to the latch; registered.
- Q_fb, input, 1: latch Q; asynchronous to clk, so it passes through a 2-flop synchroniser to form q_sync.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when a request finishes, whether it succeeds or fails.
- err, output, 1: one-cycle pulse, coincident with done, when the request timed out.
- level_q, output, 1: last confirmed latch level.

Behaviour:
- Reset values: S=0, R=0, req_ready=1, busy=0, done=0, err=0, level_q=0, both synchroniser flops=0, state=IDLE, counters=0.
- Reset mid-operation: the active-low reset clears S/R immediately, without waiting for a clock edge. No pending request survives reset.
- Handshake:
  - A request is accepted on a rising edge where req_valid and req_ready are both high.
  - req_level is captured into lvl at acceptance.
  - req_valid high while req_ready is low is ignored and not queued.
- FSM states: IDLE, PULSE, GAP, CHECK.
- IDLE:
  - On accept with lvl == q_sync: no pulse is generated. The state stays IDLE, done pulses in the next cycle, err=0, and level_q is set to lvl. req_ready stays high, so a new request may be accepted in the same cycle that done is high.
  - On accept with lvl != q_sync: go to PULSE. S=lvl and R=~lvl become active from the next cycle.
- PULSE:
  - Exactly one of S or R is high for exactly PULSE_W cycles.
  - Then both go low and the FSM moves to GAP, or to CHECK if GAP_W=0.
- GAP: S=R=0 for GAP_W cycles, then go to CHECK with the timeout counter at 0.
- CHECK:
  - S=R=0 each cycle.
  - If q_sync == lvl: done=1, level_q=lvl, and go to IDLE on the next edge.
  - Else increment the counter. If the counter reaches TIMEOUT: done=1, err=1, level_q unchanged, go to IDLE.
  - done, err and req_ready=1 all appear in the same cycle.
- Latency with immediate feedback, measured from the accept edge t0:
  - S/R is high in cycles t0+1 .. t0+PULSE_W.
  - done is high at t0+PULSE_W+GAP_W+2.
  - Timeout case: done/err are high at t0+PULSE_W+GAP_W+TIMEOUT+1.
- Invariant: S&R == 0 in every cycle, including reset and state transitions.
- Counters are sized as $clog2(max(PULSE_W, GAP_W, TIMEOUT)+1) bits and cannot overflow.
- q_sync is used only in IDLE and CHECK. Feedback glitches during PULSE/GAP are ignored.

Test Plan:
(Defaults P=4, G=2, T=16; the bench connects a behavioural NOR latch from S/R to Q_fb.)
- Reset: assert rst_n=0 mid-sim -> S=R=0 asynchronously, req_ready=1, busy=0, level_q=0, done=err=0.
- Set from Q=0: accept req_level=1 at t0 -> S=1 for cycles t0+1..t0+4, R=0 throughout, done=1 at t0+8, err=0, level_q=1.
- Redundant request: Q=1, accept req_level=1 -> no S/R activity, done at t0+1, level_q=1, err=0. Then accept req_level=0 -> R pulse of 4 cycles, level_q=0.
- Stuck feedback: bench forces Q_fb=0, accept set at t0 -> S pulse of 4 cycles, then done=err=1 at t0+23, level_q stays 0.
- Back-pressure: hold req_valid=1 throughout two requests -> second is accepted only on the edge where req_ready returns high (same cycle as the first done), with no lost or duplicated pulses; assert S&R never true.
- Reset during PULSE: drop rst_n while S=1 -> S falls before the next clk edge; after release, state is IDLE and a new request runs normally.
